// File: rtl/hpi_pkg.sv
// Shared types for the HPI responder: register selects, status bits
// and the registered view of the host pins.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA_R = 2'd0,
        HPI_MBX_R  = 2'd1,
        HPI_ADDR_R = 2'd2,
        HPI_STAT_R = 2'd3
    } hpi_reg_e;

    localparam int STAT_MBX_OUT = 0;
    localparam int STAT_MBX_IN  = 1;
    localparam int STAT_MBX_OVR = 2;

    typedef struct packed {
        logic [15:0] data;
        hpi_reg_e    sel;
        logic        rd_n;
        logic        wr_n;
        logic        cs_n;
        logic        rst_n;
    } pins_t;

    localparam pins_t PINS_IDLE = '{
        data:  16'h0000,
        sel:   HPI_DATA_R,
        rd_n:  1'b1,
        wr_n:  1'b1,
        cs_n:  1'b1,
        rst_n: 1'b1
    };

    function automatic logic [15:0] status_word(
        input logic ovr,
        input logic in_full,
        input logic out_full
    );
        return {13'b0, ovr, in_full, out_full};
    endfunction

endpackage

// File: rtl/hpi_target_ram.sv
// True dual-port word RAM, registered reads on both ports.
// Port A (host) wins when both ports write the same word.
module hpi_target_ram
    import hpi_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_a,
    input  logic          we_a,
    input  logic [15:0]   wdata_a,
    output logic [15:0]   q_a,
    input  logic [AW-1:0] addr_b,
    input  logic          we_b,
    input  logic [15:0]   wdata_b,
    output logic [15:0]   q_b
);

    logic [15:0] mem [2**AW];

    // A is written last so it overrides B on a same-word collision.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= wdata_b;
        if (we_a) mem[addr_a] <= wdata_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= 16'h0000;
            q_b <= 16'h0000;
        end else begin
            q_a <= mem[addr_a];
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/hpi_target.sv
// HPI responder: shared RAM with auto-incrementing pointer, two
// mailboxes, status register and host interrupt behind 4 registers.
module hpi_target
    import hpi_pkg::*;
#(
    parameter int MEM_AW   = 10,
    parameter int ADDR_INC = 2
) (
    input  logic              Clk,
    input  logic              Reset_N,
    inout  wire  [15:0]       HPI_DATA,
    input  logic [1:0]        HPI_ADDR,
    input  logic              HPI_RD_N,
    input  logic              HPI_WR_N,
    input  logic              HPI_CS_N,
    input  logic              HPI_RST_N,
    output logic              HPI_INT,
    input  logic [MEM_AW-1:0] loc_addr,
    input  logic              loc_wr,
    input  logic [15:0]       loc_wdata,
    output logic [15:0]       loc_rdata,
    input  logic              mbx_out_wr,
    input  logic [15:0]       mbx_out_data,
    output logic              mbx_in_valid,
    output logic [15:0]       mbx_in_data,
    input  logic              mbx_in_ack
);

    pins_t       s1;
    logic        rd_prev, wr_prev;
    logic [15:0] addr_q, rd_q, mbx_out_q, mbx_in_q, ram_q;
    logic        drive_en, mbx_out_full, mbx_in_full, mbx_in_ovr;
    logic        active, wr_fall, rd_fall, ram_we;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            s1      <= PINS_IDLE;
            rd_prev <= 1'b1;
            wr_prev <= 1'b1;
        end else begin
            s1 <= '{
                data:  HPI_DATA,
                sel:   hpi_reg_e'(HPI_ADDR),
                rd_n:  HPI_RD_N,
                wr_n:  HPI_WR_N,
                cs_n:  HPI_CS_N,
                rst_n: HPI_RST_N
            };
            rd_prev <= s1.rd_n;
            wr_prev <= s1.wr_n;
        end
    end

    assign active  = !s1.cs_n && s1.rst_n;
    assign wr_fall = active && !s1.wr_n && wr_prev;
    assign rd_fall = active && !s1.rd_n && rd_prev && s1.wr_n;
    assign ram_we  = wr_fall && (s1.sel == HPI_DATA_R);

    hpi_target_ram #(.AW(MEM_AW)) u_ram (
        .clk     (Clk),
        .rst_n   (Reset_N),
        .addr_a  (addr_q[MEM_AW:1]),
        .we_a    (ram_we),
        .wdata_a (s1.data),
        .q_a     (ram_q),
        .addr_b  (loc_addr),
        .we_b    (loc_wr),
        .wdata_b (loc_wdata),
        .q_b     (loc_rdata)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            addr_q       <= 16'h0000;
            rd_q         <= 16'h0000;
            drive_en     <= 1'b0;
            mbx_out_q    <= 16'h0000;
            mbx_out_full <= 1'b0;
            mbx_in_q     <= 16'h0000;
            mbx_in_full  <= 1'b0;
            mbx_in_ovr   <= 1'b0;
        end else begin
            if (s1.rd_n || s1.cs_n) drive_en <= 1'b0;
            if (mbx_in_ack) mbx_in_full <= 1'b0;
            if (mbx_out_wr) mbx_out_q <= mbx_out_data;
            if (wr_fall) begin
                unique case (s1.sel)
                    HPI_DATA_R: addr_q <= addr_q + 16'(ADDR_INC);
                    HPI_MBX_R: begin
                        mbx_in_q    <= s1.data;
                        mbx_in_full <= 1'b1;
                        if (mbx_in_full && !mbx_in_ack) mbx_in_ovr <= 1'b1;
                    end
                    HPI_ADDR_R: addr_q <= s1.data;
                    HPI_STAT_R: if (s1.data[STAT_MBX_OVR]) mbx_in_ovr <= 1'b0;
                endcase
            end
            if (rd_fall) begin
                drive_en <= 1'b1;
                unique case (s1.sel)
                    HPI_DATA_R: begin
                        rd_q   <= ram_q;
                        addr_q <= addr_q + 16'(ADDR_INC);
                    end
                    HPI_MBX_R: begin
                        rd_q         <= mbx_out_q;
                        mbx_out_full <= 1'b0;
                    end
                    HPI_ADDR_R: rd_q <= addr_q;
                    HPI_STAT_R: rd_q <= status_word(mbx_in_ovr, mbx_in_full,
                                                    mbx_out_full);
                endcase
            end
            // A device load in the same cycle as a host read keeps the flag.
            if (mbx_out_wr) mbx_out_full <= 1'b1;
            if (!s1.rst_n) begin
                addr_q       <= 16'h0000;
                drive_en     <= 1'b0;
                mbx_out_full <= 1'b0;
                mbx_in_full  <= 1'b0;
                mbx_in_ovr   <= 1'b0;
            end
        end
    end

    assign HPI_DATA     = drive_en ? rd_q : 16'hzzzz;
    assign HPI_INT      = mbx_out_full;
    assign mbx_in_valid = mbx_in_full;
    assign mbx_in_data  = mbx_in_q;

endmodule

// File: tb/tb_hpi_target.sv
// Directed and randomized checks of hpi_target against a
// register-level model of the host port.
module tb_hpi_target;
    import hpi_pkg::*;

    localparam int AW = 10;

    logic          Clk = 1'b0;
    logic          Reset_N = 1'b0;
    wire  [15:0]   HPI_DATA;
    logic [1:0]    HPI_ADDR = 2'd0;
    logic          HPI_RD_N = 1'b1, HPI_WR_N = 1'b1, HPI_CS_N = 1'b1;
    logic          HPI_RST_N = 1'b1;
    logic          HPI_INT;
    logic [AW-1:0] loc_addr = '0;
    logic          loc_wr = 1'b0;
    logic [15:0]   loc_wdata = 16'h0, loc_rdata;
    logic          mbx_out_wr = 1'b0;
    logic [15:0]   mbx_out_data = 16'h0;
    logic          mbx_in_valid;
    logic [15:0]   mbx_in_data;
    logic          mbx_in_ack = 1'b0;

    logic [15:0]   hd = 16'h0;
    logic          hd_oe = 1'b0;
    assign HPI_DATA = hd_oe ? hd : 16'hzzzz;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    logic [15:0] m_mem [1024];
    bit          m_val [1024];
    logic [15:0] m_addr, m_out_data, m_in_data;
    bit          m_out_full, m_in_full, m_ovr;

    always #5 Clk = ~Clk;

    hpi_target #(.MEM_AW(AW), .ADDR_INC(2)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .HPI_DATA(HPI_DATA),
        .HPI_ADDR(HPI_ADDR), .HPI_RD_N(HPI_RD_N), .HPI_WR_N(HPI_WR_N),
        .HPI_CS_N(HPI_CS_N), .HPI_RST_N(HPI_RST_N), .HPI_INT(HPI_INT),
        .loc_addr(loc_addr), .loc_wr(loc_wr), .loc_wdata(loc_wdata),
        .loc_rdata(loc_rdata), .mbx_out_wr(mbx_out_wr),
        .mbx_out_data(mbx_out_data), .mbx_in_valid(mbx_in_valid),
        .mbx_in_data(mbx_in_data), .mbx_in_ack(mbx_in_ack)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {15'b0, obs}, {15'b0, exp});
    endtask

    // Bus released: our own weak pattern must read back untouched.
    task automatic probe_released(input string tag);
        hd = 16'h0000;
        hd_oe = 1'b1;
        #1;
        chk(tag, HPI_DATA, 16'h0000);
        hd_oe = 1'b0;
    endtask

    // side 1: local write to word 16, side 2: ack, side 3: RD_N also low
    task automatic hwr(input logic [1:0] sel, input logic [15:0] d,
                       input int side = 0);
        @(negedge Clk);
        HPI_ADDR = sel; hd = d; hd_oe = 1'b1;
        HPI_CS_N = 1'b0; HPI_WR_N = 1'b0;
        if (side == 3) HPI_RD_N = 1'b0;
        @(negedge Clk);
        if (side == 1) begin
            loc_addr = 10'd16; loc_wdata = 16'hDEAD; loc_wr = 1'b1;
        end
        if (side == 2) mbx_in_ack = 1'b1;
        @(negedge Clk);
        loc_wr = 1'b0; mbx_in_ack = 1'b0;
        @(negedge Clk);
        HPI_WR_N = 1'b1; HPI_RD_N = 1'b1; HPI_CS_N = 1'b1; hd_oe = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    // side 1: device loads 16'h2222 into the outgoing mailbox mid-read
    task automatic hrd(input logic [1:0] sel, output logic [15:0] d,
                       input int side = 0);
        @(negedge Clk);
        HPI_ADDR = sel; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        @(negedge Clk);
        if (side == 1) begin
            mbx_out_data = 16'h2222; mbx_out_wr = 1'b1;
        end
        @(negedge Clk);
        mbx_out_wr = 1'b0;
        @(negedge Clk);
        d = HPI_DATA;
        HPI_RD_N = 1'b1; HPI_CS_N = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic lwr(input int a, input logic [15:0] d);
        @(negedge Clk);
        loc_addr = AW'(a); loc_wdata = d; loc_wr = 1'b1;
        @(negedge Clk);
        loc_wr = 1'b0;
    endtask

    task automatic lrd(input int a, output logic [15:0] d);
        @(negedge Clk);
        loc_addr = AW'(a);
        @(negedge Clk);
        d = loc_rdata;
    endtask

    task automatic mout(input logic [15:0] d);
        @(negedge Clk);
        mbx_out_data = d; mbx_out_wr = 1'b1;
        @(negedge Clk);
        mbx_out_wr = 1'b0;
    endtask

    task automatic ack();
        @(negedge Clk);
        mbx_in_ack = 1'b1;
        @(negedge Clk);
        mbx_in_ack = 1'b0;
    endtask

    function automatic int midx(input logic [15:0] a);
        return (int'(a) / 2) % 1024;
    endfunction

    initial begin
        logic [15:0] r, d, a;
        int op, wi;

        repeat (3) @(negedge Clk);
        chk1("rst_int", HPI_INT, 1'b0);
        chk1("rst_valid", mbx_in_valid, 1'b0);
        chk("rst_inbox", mbx_in_data, 16'h0000);
        chk("rst_locq", loc_rdata, 16'h0000);
        probe_released("rst_bus");
        Reset_N = 1'b1;
        repeat (2) @(negedge Clk);

        hwr(HPI_ADDR_R, 16'h0010);
        hwr(HPI_DATA_R, 16'hAAAA);
        hwr(HPI_DATA_R, 16'h5555);
        hrd(HPI_ADDR_R, r); chk("t1_addr", r, 16'h0014);
        lrd(8, r); chk("t1_mem8", r, 16'hAAAA);
        lrd(9, r); chk("t1_mem9", r, 16'h5555);

        lwr(3, 16'h1234);
        hwr(HPI_ADDR_R, 16'h0006);
        @(negedge Clk);
        HPI_ADDR = HPI_DATA_R; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        @(negedge Clk);
        probe_released("t2_cycN");
        @(negedge Clk);
        chk("t2_cycN1", HPI_DATA, 16'h1234);
        @(negedge Clk);
        HPI_RD_N = 1'b1; HPI_CS_N = 1'b1;
        repeat (2) @(negedge Clk);
        probe_released("t2_release");
        hrd(HPI_ADDR_R, r); chk("t2_addr", r, 16'h0008);

        mout(16'hBEEF);
        chk1("t3_int", HPI_INT, 1'b1);
        hrd(HPI_STAT_R, r); chk("t3_stat", r, 16'h0001);
        hrd(HPI_MBX_R, r); chk("t3_mbx", r, 16'hBEEF);
        chk1("t3_int_clr", HPI_INT, 1'b0);
        hrd(HPI_STAT_R, r); chk("t3_stat_clr", r, 16'h0000);

        hwr(HPI_MBX_R, 16'h1111);
        hwr(HPI_MBX_R, 16'h2222);
        chk("t4_data", mbx_in_data, 16'h2222);
        chk1("t4_valid", mbx_in_valid, 1'b1);
        hrd(HPI_STAT_R, r); chk("t4_stat_ovr", r, 16'h0006);
        hwr(HPI_STAT_R, 16'h0004);
        hrd(HPI_STAT_R, r); chk("t4_stat_w1c", r, 16'h0002);
        ack();
        chk1("t4_ack", mbx_in_valid, 1'b0);

        lwr(0, 16'h0A0A);
        hwr(HPI_ADDR_R, 16'hFFFE);
        hwr(HPI_DATA_R, 16'h7E57);
        hrd(HPI_ADDR_R, r); chk("t5_wrap", r, 16'h0000);
        lrd(1023, r); chk("t5_top", r, 16'h7E57);
        hrd(HPI_DATA_R, r); chk("t5_mem0", r, 16'h0A0A);

        hwr(HPI_ADDR_R, 16'h0020);
        hwr(HPI_DATA_R, 16'hC0DE, 1);
        lrd(16, r); chk("col_ram", r, 16'hC0DE);
        mout(16'h1111);
        hrd(HPI_MBX_R, r, 1); chk("col_mbx_old", r, 16'h1111);
        chk1("col_int_kept", HPI_INT, 1'b1);
        hrd(HPI_MBX_R, r); chk("col_mbx_new", r, 16'h2222);
        hwr(HPI_MBX_R, 16'h3333);
        hwr(HPI_MBX_R, 16'h4444, 2);
        chk("col_ack_data", mbx_in_data, 16'h4444);
        hrd(HPI_STAT_R, r); chk("col_ack_stat", r, 16'h0002);
        ack();
        hwr(HPI_ADDR_R, 16'h0100, 3);
        hrd(HPI_ADDR_R, r); chk("col_both", r, 16'h0100);

        hwr(HPI_ADDR_R, 16'd40);
        mout(16'h1357);
        hwr(HPI_MBX_R, 16'h2468);
        chk1("t6_int_pre", HPI_INT, 1'b1);
        @(negedge Clk); HPI_RST_N = 1'b0;
        repeat (3) @(negedge Clk); HPI_RST_N = 1'b1;
        repeat (2) @(negedge Clk);
        chk1("t6_int", HPI_INT, 1'b0);
        chk1("t6_valid", mbx_in_valid, 1'b0);
        chk("t6_keep", mbx_in_data, 16'h2468);
        hrd(HPI_ADDR_R, r); chk("t6_addr", r, 16'h0000);
        hrd(HPI_STAT_R, r); chk("t6_stat", r, 16'h0000);
        lrd(8, r); chk("t6_ram", r, 16'hAAAA);

        hwr(HPI_ADDR_R, 16'h0010);
        @(negedge Clk);
        HPI_ADDR = HPI_DATA_R; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        repeat (2) @(negedge Clk);
        chk("t7_drive", HPI_DATA, 16'hAAAA);
        #1 Reset_N = 1'b0;
        #1 probe_released("t7_async");
        chk("t7_inbox", mbx_in_data, 16'h0000);
        @(negedge Clk);
        HPI_RD_N = 1'b1; HPI_CS_N = 1'b1;
        @(negedge Clk); Reset_N = 1'b1;
        repeat (2) @(negedge Clk);
        hrd(HPI_ADDR_R, r); chk("t7_addr", r, 16'h0000);

        m_addr = 16'h0; m_out_full = 0; m_in_full = 0; m_ovr = 0;
        m_in_data = 16'h0; m_out_data = 16'h0;
        for (int i = 0; i < 1024; i++) m_val[i] = 0;
        for (int i = 0; i < 72; i++) begin
            wi = (i < 64) ? i : 1016 + i - 64;
            d = 16'($urandom);
            lwr(wi, d);
            m_mem[wi] = d; m_val[wi] = 1;
        end

        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 7);
            d = 16'($urandom);
            case (op)
                0: begin
                    hwr(HPI_DATA_R, d);
                    m_mem[midx(m_addr)] = d; m_val[midx(m_addr)] = 1;
                    m_addr = m_addr + 16'd2;
                end
                1: begin
                    hrd(HPI_DATA_R, r);
                    if (m_val[midx(m_addr)]) chk("r_data", r, m_mem[midx(m_addr)]);
                    m_addr = m_addr + 16'd2;
                end
                2: begin
                    if ($urandom_range(0, 3) == 0)
                        a = 16'hFFF0 + 16'($urandom_range(0, 15));
                    else
                        a = 16'($urandom_range(0, 127));
                    hwr(HPI_ADDR_R, a);
                    m_addr = a;
                end
                3: begin
                    hrd(HPI_ADDR_R, r);
                    chk("r_addr", r, m_addr);
                end
                4: begin
                    if (d[0]) begin
                        hwr(HPI_STAT_R, d);
                        if (d[2]) m_ovr = 0;
                    end
                    hrd(HPI_STAT_R, r);
                    chk("r_stat", r, {13'b0, m_ovr, m_in_full, m_out_full});
                end
                5: begin
                    wi = $urandom_range(0, 63);
                    if (d[15]) begin
                        lwr(wi, d);
                        m_mem[wi] = d; m_val[wi] = 1;
                    end else begin
                        lrd(wi, r);
                        if (m_val[wi]) chk("r_loc", r, m_mem[wi]);
                    end
                end
                6: begin
                    mout(d);
                    m_out_data = d; m_out_full = 1;
                    if (d[0]) begin
                        hrd(HPI_MBX_R, r);
                        chk("r_mbx_out", r, m_out_data);
                        m_out_full = 0;
                    end
                end
                default: begin
                    hwr(HPI_MBX_R, d);
                    if (m_in_full) m_ovr = 1;
                    m_in_full = 1; m_in_data = d;
                    chk("r_mbx_in", mbx_in_data, m_in_data);
                    if (d[1]) begin
                        ack();
                        m_in_full = 0;
                    end
                    chk1("r_valid", mbx_in_valid, m_in_full);
                end
            endcase
            chk1("r_int", HPI_INT, m_out_full);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hpi_target.md
Name: hpi_target

Overview:
- HPI responder: the slave end of the 4-register HPI port, emulating the EZ-OTG host-port register file.
- Sits on the OTG_* pins opposite the NIOS-side HPI initiator, either on-chip for loop-back bring-up or as the bench model for the initiator.
- Provides a word-addressed shared RAM with an auto-incrementing pointer, a bidirectional mailbox, a status register and a host interrupt.
- A local (device-side) port gives on-chip logic access to the RAM and the mailbox.

Parameters:
- MEM_AW, 10, RAM word-address width (2**MEM_AW 16-bit words).
- ADDR_INC, 2, byte increment applied to ADDRESS after every DATA access.

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  asynchronous active-low reset.
- HPI_DATA  inout  16  HPI data bus; high-Z unless read-driving.
- HPI_ADDR  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- HPI_RD_N, HPI_WR_N, HPI_CS_N  in  1 each  active-low strobes.
- HPI_RST_N  in  1  active-low soft reset from the host.
- HPI_INT  out  1  high while a device-to-host mailbox word is pending.
- loc_addr  in  MEM_AW  local RAM word address.
- loc_wr  in  1  local RAM write enable.
- loc_wdata  in  16  local RAM write data.
- loc_rdata  out  16  mem[loc_addr], 1-cycle latency.
- mbx_out_wr  in  1  load mbx_out_data into device-to-host mailbox.
- mbx_out_data  in  16  device-to-host word.
- mbx_in_valid  out  1  host-to-device word pending.
- mbx_in_data  out  16  host-to-device word.
- mbx_in_ack  in  1  pulse: consume mbx_in.

Behaviour:
- Reset is asynchronous, active-low on Reset_N. On reset:
  - addr_q = 0, mbx_out_full = 0, mbx_in_full = 0, mbx_in_ovr = 0.
  - HPI_INT = 0, mbx_in_valid = 0, mbx_in_data = 0, loc_rdata = 0.
  - HPI_DATA tri-stated; RAM contents not reset.
- Pin capture: every HPI_* input is registered once (s1), plus a previous copy (s2). All decisions use s1/s2.
- Events, all gated by s1.CS_N = 0:
  - wr_fall: s1.WR_N = 0 and s2.WR_N = 1.
  - rd_fall: s1.RD_N = 0, s2.RD_N = 1 and s1.WR_N = 1. If both strobes are low, the write wins and there is no drive.
- Write actions (wr_fall), using s1.DATA:
  - DATA: mem[addr_q[MEM_AW:1]] ← data; addr_q += ADDR_INC.
  - MAILBOX: mbx_in_data ← data; mbx_in_full ← 1. If already full, set sticky mbx_in_ovr.
  - ADDRESS: addr_q ← data.
  - STATUS: write-1-to-clear bit2 (mbx_in_ovr); other bits ignored.
- Read actions (rd_fall): rd_q ← selected value and drive_en ← 1.
  - DATA: prefetched RAM output; the RAM read port is continuously addressed by addr_q. Then addr_q += ADDR_INC.
  - MAILBOX: mbx_out reg; clears mbx_out_full and HPI_INT.
  - ADDRESS: addr_q.
  - STATUS: {13'b0, mbx_in_ovr, mbx_in_full, mbx_out_full}.
- Drive timing:
  - HPI_DATA = rd_q while drive_en, else high-Z.
  - drive_en clears the cycle s1.RD_N = 1 or s1.CS_N = 1.
  - Read-data latency: the pin edge is captured at s1 (cycle N); rd_q is driven from cycle N+1.
- Strobe constraints: minimum strobe low width 3 Clk; minimum gap between strobes 2 Clk. This guarantees the prefetch is valid after an ADDRESS write or auto-increment.
- Address arithmetic: addr_q is 16 bits and wraps at 16'hFFFF→0. RAM index uses addr_q[MEM_AW:1], so the index wraps at the RAM top; bit0 is ignored.
- Mailbox, device to host:
  - mbx_out_wr sets mbx_out_full and HPI_INT and loads the data.
  - mbx_out_wr in the same cycle as a host MAILBOX read: the read returns the old value; the new value loads and full/INT stay set (set wins).
- Mailbox, host to device:
  - mbx_in_valid = mbx_in_full; mbx_in_ack clears it.
  - Ack in the same cycle as a host MAILBOX write: full stays set with the new data; no overrun is flagged.
- RAM collision: same-cycle host and local writes to the same word → the host write wins.
- Soft reset: s1.RST_N = 0 synchronously clears addr_q, all mailbox flags, ovr, HPI_INT and drive_en, and ignores strobes. RAM and mbx data registers are retained.
- Async reset mid-transaction: the bus releases immediately; a partial write is never committed.

Decomposition:
- Package hpi_pkg:
  - enum hpi_reg_e {HPI_DATA_R = 2'd0, HPI_MBX_R, HPI_ADDR_R, HPI_STAT_R}.
  - Status bit indices STAT_MBX_OUT = 0, STAT_MBX_IN = 1, STAT_MBX_OVR = 2.
- Sub-module hpi_target_ram: true dual-port, 2**MEM_AW×16, registered read on both ports, port A host / port B local, write-wins priority on A.

Test Plan:
- Write ADDRESS = 16'h0010, then DATA writes 16'hAAAA, 16'h5555 → mem[8] = AAAA, mem[9] = 5555; ADDRESS readback = 16'h0014.
- Local loc_wr mem[3] = 16'h1234; host writes ADDRESS = 6 and reads DATA → HPI_DATA = 1234 from cycle N+1; high-Z after RD_N rises; ADDRESS = 8.
- mbx_out_wr 16'hBEEF → HPI_INT = 1, STATUS = 16'h0001; host MAILBOX read → BEEF, then HPI_INT = 0 and STATUS = 0.
- Two host MAILBOX writes (1111, 2222) without ack → mbx_in_data = 2222, STATUS = 16'h0006; host STATUS write 16'h0004 → 16'h0002; mbx_in_ack → 0.
- ADDRESS = 16'hFFFE with MEM_AW = 10, DATA write → addr_q = 0, mem[1023] written; next DATA read returns mem[0].
- HPI_RST_N low with a pending mailbox and addr_q = 40 → flags, INT and addr_q = 0; RAM intact. Reset_N low mid-read → HPI_DATA is high-Z in the same cycle.
